// File: rtl/ipv4_chksum_pkg.sv
// ipv4_chksum_pkg: shared types and field positions for the
// IPv4 header checksum controller and its fold helper.
package ipv4_chksum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned IHL_LSB      = 24;
  localparam int unsigned IHL_W        = 4;
  localparam int unsigned VER_LSB      = 28;
  localparam int unsigned VER_W        = 4;
  localparam int unsigned IPV4_VERSION = 4;

  // 15 words x 2 halves x 16'hFFFF stays below 2^21
  localparam int unsigned ACC_W        = 21;

endpackage

// File: rtl/ipv4_chksum_ctrl_fold.sv
// ones_fold16: combinational end-around-carry fold of a 21-bit
// ones'-complement partial sum. Ports: a (ACC_W) in, y (16) out.
module ones_fold16
  import ipv4_chksum_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  output logic [15:0]      y
);

  logic [16:0] s1;
  logic [15:0] s2;

  // s1 <= 16'hFFFF + 5'h1F, so the second
  // fold can never carry out again
  assign s1 = {1'b0, a[15:0]}
            + 17'(a[ACC_W-1:16]);
  assign s2 = s1[15:0] + 16'(s1[16]);
  assign y  = s2;

endmodule

// File: rtl/ipv4_chksum_ctrl.sv
// ipv4_chksum_ctrl: streams IPv4 header words over s_valid/s_ready,
// sizes the header from IHL, sums it and returns the checksum over
// cks_valid/cks_ready with cks_value, cks_err and, when the macro
// CHKSUM_VERIFY_EN is defined, cks_ok (received checksum correct).
// Ports: clk, rst_n (async low), s_valid/s_ready/s_data[31:0],
// cks_valid/cks_ready/cks_value[15:0]/cks_err[/cks_ok].
module ipv4_chksum_ctrl #(
  parameter int unsigned MIN_IHL = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        cks_valid,
  input  logic        cks_ready,
  output logic [15:0] cks_value,
`ifdef CHKSUM_VERIFY_EN
  output logic        cks_err,
  output logic        cks_ok
`else
  output logic        cks_err
`endif
);

  import ipv4_chksum_pkg::*;

  localparam logic [IHL_W-1:0] MIN_V =
    IHL_W'(MIN_IHL);
  localparam logic [VER_W-1:0] VER_V =
    VER_W'(IPV4_VERSION);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [IHL_W-1:0] words_left;
  logic             err_q;

  logic [IHL_W-1:0] ihl;
  logic [VER_W-1:0] ver;
  logic             ihl_short;
  logic [IHL_W-1:0] ihl_eff;
  logic [16:0]      half_sum;
  logic [15:0]      fold_sum;

  assign ihl       = s_data[IHL_LSB +: IHL_W];
  assign ver       = s_data[VER_LSB +: VER_W];
  assign ihl_short = ihl < MIN_V;
  assign ihl_eff   = ihl_short ? MIN_V : ihl;
  assign half_sum  = {1'b0, s_data[31:16]}
                   + {1'b0, s_data[15:0]};

  ones_fold16 u_fold (
    .a (acc),
    .y (fold_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    cks_valid = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = ACC;
      end
      ACC: begin
        s_ready = 1'b1;
        if (s_valid && words_left == 4'd1)
          state_nxt = FOLD;
      end
      FOLD: state_nxt = DONE;
      DONE: begin
        cks_valid = 1'b1;
        if (cks_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      words_left <= '0;
      err_q      <= 1'b0;
      cks_value  <= 16'h0000;
      cks_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (s_valid) begin
          acc        <= ACC_W'(half_sum);
          words_left <= ihl_eff - 4'd1;
          err_q      <= ihl_short | (ver != VER_V);
        end
        ACC: if (s_valid) begin
          acc        <= acc + ACC_W'(half_sum);
          words_left <= words_left - 4'd1;
        end
        FOLD: begin
          cks_value <= ~fold_sum;
          cks_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

`ifdef CHKSUM_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_ok <= 1'b0;
    end else if (state == FOLD) begin
      cks_ok <= fold_sum == 16'hFFFF;
    end
  end
`endif

endmodule

// File: tb/tb_ipv4_chksum_ctrl.sv
// tb_ipv4_chksum_ctrl: directed and random headers against an
// arithmetic checksum model; checks timing, errors and reset.
module tb_ipv4_chksum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        cks_valid;
  logic        cks_ready;
  logic [15:0] cks_value;
  logic        cks_err;
`ifdef CHKSUM_VERIFY_EN
  logic        cks_ok;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ipv4_chksum_ctrl #(.MIN_IHL(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .cks_valid (cks_valid),
    .cks_ready (cks_ready),
    .cks_value (cks_value),
`ifdef CHKSUM_VERIFY_EN
    .cks_err   (cks_err),
    .cks_ok    (cks_ok)
`else
    .cks_err   (cks_err)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int ref_len(input logic [31:0] w0);
    int ihl;
    ihl = int'(w0[27:24]);
    return (ihl < 5) ? 5 : ihl;
  endfunction

  function automatic bit ref_err(input logic [31:0] w0);
    return (w0[31:28] != 4'd4) || (w0[27:24] < 4'd5);
  endfunction

  // {ok, checksum}: plain 32-bit sum of halves, folded until
  // no carry remains
  function automatic logic [16:0] ref_cks(
      input logic [31:0] hdr[16], input int n);
    int unsigned s;
    logic [31:0] w;
    s = 0;
    for (int i = 0; i < n; i++) begin
      w = hdr[i];
      s += int'(w[31:16]) + int'(w[15:0]);
    end
    while ((s >> 16) != 0)
      s = (s & 32'hFFFF) + (s >> 16);
    return {s[15:0] == 16'hFFFF, ~s[15:0]};
  endfunction

  task automatic push(input logic [31:0] w,
                      input int maxgap,
                      input string tag);
    int n;
    bit hs;
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 40) begin
      hs = s_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    s_data  = $urandom;
    check({tag, "_hs"}, 32'(hs), 32'd1);
  endtask

  task automatic run_header(input logic [31:0] hdr[16],
                            input int maxgap,
                            input int hold,
                            input string tag);
    int n;
    logic [16:0] r;
    bit e;
    n = ref_len(hdr[0]);
    r = ref_cks(hdr, n);
    e = ref_err(hdr[0]);
    for (int i = 0; i < n; i++) push(hdr[i], maxgap, tag);
    check({tag, "_fold_valid"}, 32'(cks_valid), 32'd0);
    check({tag, "_fold_ready"}, 32'(s_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(cks_valid), 32'd1);
    check({tag, "_value"}, 32'(cks_value), 32'(r[15:0]));
    check({tag, "_err"}, 32'(cks_err), 32'(e));
`ifdef CHKSUM_VERIFY_EN
    check({tag, "_ok"}, 32'(cks_ok), 32'(r[16]));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(cks_valid), 32'd1);
      check({tag, "_hold_value"}, 32'(cks_value),
            32'(r[15:0]));
      check({tag, "_hold_sready"}, 32'(s_ready), 32'd0);
    end
    cks_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cks_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_drop"}, 32'(cks_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] h[16];
    logic [31:0] base[16];

    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    cks_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sready", 32'(s_ready), 32'd1);
    check("rst_valid", 32'(cks_valid), 32'd0);
    check("rst_value", 32'(cks_value), 32'd0);
    check("rst_err", 32'(cks_err), 32'd0);
`ifdef CHKSUM_VERIFY_EN
    check("rst_ok", 32'(cks_ok), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) base[i] = '0;
    base[0] = 32'h45000073;
    base[1] = 32'h00004000;
    base[2] = 32'h40110000;
    base[3] = 32'hc0a80001;
    base[4] = 32'hc0a800c7;

    // known vector: checksum must be 16'hB861
    h = base;
    for (int i = 0; i < 5; i++) push(h[i], 0, "vec");
    @(negedge clk);
    check("vec_const", 32'(cks_value), 32'h0000B861);
    check("vec_const_err", 32'(cks_err), 32'd0);
    cks_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cks_ready = 1'b0;
    run_header(h, 0, 0, "vec_model");

    h[2] = 32'h4011B861;
    run_header(h, 0, 0, "verify_good");
    h[2] = 32'h4011B862;
    run_header(h, 0, 0, "verify_bad");

    h = base;
    h[0] = 32'h43000073;
    run_header(h, 0, 0, "ihl3");
    h[0] = 32'h65000073;
    run_header(h, 0, 0, "ver6");

    for (int i = 0; i < 16; i++) h[i] = 32'hFFFFFFFF;
    run_header(h, 0, 0, "ihl15");

    h = base;
    run_header(h, 0, 10, "hold");
    run_header(h, 0, 0, "b2b");

    // reset mid-header
    h = base;
    push(h[0], 2, "rstmid");
    push(h[1], 2, "rstmid");
    push(h[2], 2, "rstmid");
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_sready", 32'(s_ready), 32'd1);
    check("rstmid_valid", 32'(cks_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_header(h, 2, 0, "after_rst");

    // reset while result is pending
    for (int i = 0; i < 5; i++) push(h[i], 1, "rstdone");
    @(negedge clk);
    check("rstdone_pre", 32'(cks_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstdone_valid", 32'(cks_valid), 32'd0);
    check("rstdone_value", 32'(cks_value), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstdone_noemit", 32'(cks_valid), 32'd0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) h[i] = $urandom;
      h[0][31:28] = ($urandom_range(0, 7) == 0)
                  ? 4'($urandom) : 4'd4;
      h[0][27:24] = ($urandom_range(0, 5) == 0)
                  ? 4'($urandom_range(0, 4))
                  : 4'($urandom_range(5, 15));
      run_header(h, 3, $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
